exception_beta: RTL and testbench

- Parametrised successor to the commit-stage exception unit.
- Prioritises commit-stage exceptions and synchronised external interrupts, then registers the CP0 update.
- Sequences a precise pipeline flush and a front-end redirect handshake through a small FSM.
- Sits between the commit stage, CP0 and the fetch unit; stalls commit until the redirect is accepted.

---
 rtl/exception_beta.sv | 155 +++++++++++++++
 tb/tb_exception_beta.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/exception_beta.sv
// Commit-stage exception unit: picks the highest-priority commit event or enabled interrupt,
// registers the CP0 update, then runs a flush / front-end redirect sequence while commit stalls.
module exception_beta #(
  parameter int          N_INT        = 8,
  parameter int          SYNC_STAGES  = 2,
  parameter logic [31:0] EXC_VECTOR   = 32'hbfc00380,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             commit_valid,
  input  logic             iaddr_alignment_error,
  input  logic             daddr_alignment_error,
  input  logic             invalid_instruction,
  input  logic             priv_instruction,
  input  logic             syscall,
  input  logic             break_,
  input  logic             eret,
  input  logic             overflow,
  input  logic             mem_wen,
  input  logic             is_branch_slot,
  input  logic [31:0]      pc_address,
  input  logic [31:0]      mem_address,
  input  logic [31:0]      epc_address,
  input  logic             status_ie,
  input  logic             status_exl,
  input  logic [N_INT-1:0] int_mask,
  input  logic [N_INT-1:0] int_raw,
  output logic [N_INT-1:0] int_pending,
  output logic             commit_stall,
  output logic             flush,
  output logic             redirect_valid,
  input  logic             redirect_ready,
  output logic [31:0]      redirect_pc,
  output logic             cp0_exp_en,
  output logic             cp0_exl_clean,
  output logic             cp0_exp_bd,
  output logic             cp0_exp_bad_vaddr_wen,
  output logic [4:0]       cp0_exp_code,
  output logic [31:0]      cp0_exp_epc,
  output logic [31:0]      cp0_exp_bad_vaddr,
  output logic [1:0]       fsm_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, FLUSH = 2'd1, REDIRECT = 2'd2} state_t;

  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  state_t          state, state_next;
  logic [CW-1:0]   flush_cnt;
  logic [N_INT-1:0] sync_q [SYNC_STAGES];

  logic        int_take;
  logic        ev;
  logic        ev_eret;
  logic        ev_bv_wen;
  logic [4:0]  ev_code;
  logic [31:0] ev_bv;
  logic        capture;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= int_raw;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign int_pending = sync_q[SYNC_STAGES-1] & int_mask;
  assign int_take    = commit_valid & status_ie & ~status_exl & (|int_pending);

  // Priority chain; the first matching condition owns the event.
  always_comb begin
    ev        = 1'b0;
    ev_eret   = 1'b0;
    ev_bv_wen = 1'b0;
    ev_code   = 5'h00;
    ev_bv     = pc_address;
    if (commit_valid) begin
      if (int_take) begin
        ev = 1'b1; ev_code = 5'h00;
      end else if (iaddr_alignment_error) begin
        ev = 1'b1; ev_code = 5'h04; ev_bv_wen = 1'b1; ev_bv = pc_address;
      end else if (syscall) begin
        ev = 1'b1; ev_code = 5'h08;
      end else if (break_) begin
        ev = 1'b1; ev_code = 5'h09;
      end else if (invalid_instruction) begin
        ev = 1'b1; ev_code = 5'h0a;
      end else if (priv_instruction) begin
        ev = 1'b1; ev_code = 5'h0b;
      end else if (overflow) begin
        ev = 1'b1; ev_code = 5'h0c;
      end else if (eret) begin
        ev = 1'b1; ev_eret = 1'b1;
      end else if (daddr_alignment_error) begin
        ev = 1'b1; ev_code = mem_wen ? 5'h05 : 5'h04; ev_bv_wen = 1'b1; ev_bv = mem_address;
      end
    end
  end

  assign capture = (state == IDLE) & ev;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (ev) state_next = FLUSH;
      FLUSH:    if (flush_cnt == CW'(FLUSH_CYCLES - 1)) state_next = REDIRECT;
      REDIRECT: if (redirect_ready) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      flush_cnt <= '0;
    end else begin
      state     <= state_next;
      flush_cnt <= (state == FLUSH) ? flush_cnt + 1'b1 : '0;
    end
  end

  // Strobes pulse for one cycle; captured values hold until the next event.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cp0_exp_en            <= 1'b0;
      cp0_exl_clean         <= 1'b0;
      cp0_exp_bad_vaddr_wen <= 1'b0;
      cp0_exp_bd            <= 1'b0;
      cp0_exp_code          <= 5'h00;
      cp0_exp_epc           <= 32'h0;
      cp0_exp_bad_vaddr     <= 32'h0;
      redirect_pc           <= 32'h0;
    end else begin
      cp0_exp_en            <= capture & ~ev_eret;
      cp0_exl_clean         <= capture & ev_eret;
      cp0_exp_bad_vaddr_wen <= capture & ev_bv_wen;
      if (capture) begin
        cp0_exp_bd  <= is_branch_slot;
        cp0_exp_epc <= is_branch_slot ? pc_address - 32'd4 : pc_address;
        redirect_pc <= ev_eret ? epc_address : EXC_VECTOR;
        if (!ev_eret) cp0_exp_code <= ev_code;
        if (ev_bv_wen) cp0_exp_bad_vaddr <= ev_bv;
      end
    end
  end

  assign commit_stall   = (state != IDLE);
  assign flush          = (state == FLUSH);
  assign redirect_valid = (state == REDIRECT);
  assign fsm_state      = state;

endmodule

// File: tb/tb_exception_beta.sv
// Directed bench for exception_beta: hand-computed CP0 values and flush/redirect timing.
module tb_exception_beta;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        commit_valid = 0, iaddr_alignment_error = 0, daddr_alignment_error = 0;
  logic        invalid_instruction = 0, priv_instruction = 0, syscall = 0, break_ = 0;
  logic        eret = 0, overflow = 0, mem_wen = 0, is_branch_slot = 0;
  logic [31:0] pc_address = 0, mem_address = 0, epc_address = 0;
  logic        status_ie = 0, status_exl = 0;
  logic [7:0]  int_mask = 0, int_raw = 0;
  logic [7:0]  int_pending;
  logic        commit_stall, flush, redirect_valid, redirect_ready = 0;
  logic [31:0] redirect_pc;
  logic        cp0_exp_en, cp0_exl_clean, cp0_exp_bd, cp0_exp_bad_vaddr_wen;
  logic [4:0]  cp0_exp_code;
  logic [31:0] cp0_exp_epc, cp0_exp_bad_vaddr;
  logic [1:0]  fsm_state;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  exception_beta dut (
    .clk(clk), .rst(rst), .commit_valid(commit_valid),
    .iaddr_alignment_error(iaddr_alignment_error), .daddr_alignment_error(daddr_alignment_error),
    .invalid_instruction(invalid_instruction), .priv_instruction(priv_instruction),
    .syscall(syscall), .break_(break_), .eret(eret), .overflow(overflow), .mem_wen(mem_wen),
    .is_branch_slot(is_branch_slot), .pc_address(pc_address), .mem_address(mem_address),
    .epc_address(epc_address), .status_ie(status_ie), .status_exl(status_exl),
    .int_mask(int_mask), .int_raw(int_raw), .int_pending(int_pending),
    .commit_stall(commit_stall), .flush(flush), .redirect_valid(redirect_valid),
    .redirect_ready(redirect_ready), .redirect_pc(redirect_pc), .cp0_exp_en(cp0_exp_en),
    .cp0_exl_clean(cp0_exl_clean), .cp0_exp_bd(cp0_exp_bd),
    .cp0_exp_bad_vaddr_wen(cp0_exp_bad_vaddr_wen), .cp0_exp_code(cp0_exp_code),
    .cp0_exp_epc(cp0_exp_epc), .cp0_exp_bad_vaddr(cp0_exp_bad_vaddr), .fsm_state(fsm_state)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_commit();
    commit_valid = 0; iaddr_alignment_error = 0; daddr_alignment_error = 0;
    invalid_instruction = 0; priv_instruction = 0; syscall = 0; break_ = 0;
    eret = 0; overflow = 0; mem_wen = 0; is_branch_slot = 0;
  endtask

  // Bounded wait for redirect_valid, then accept it; fails the run cleanly on timeout.
  task automatic finish_redirect(input string tag);
    int n = 0;
    clear_commit();
    while (!redirect_valid && n < 20) begin
      step();
      n++;
    end
    check({tag, "_redirect_seen"}, {31'd0, redirect_valid}, 32'd1);
    redirect_ready = 1;
    step();
    redirect_ready = 0;
    check({tag, "_back_idle"}, {31'd0, commit_stall}, 32'd0);
  endtask

  initial begin
    #12;
    check("reset_stall", {31'd0, commit_stall}, 32'd0);
    check("reset_state", {30'd0, fsm_state}, 32'd0);
    rst = 1;
    step();

    // syscall: full timing of flush and redirect hold
    commit_valid = 1; syscall = 1; pc_address = 32'h80001000;
    step();
    clear_commit();
    check("sys_en", {31'd0, cp0_exp_en}, 32'd1);
    check("sys_code", {27'd0, cp0_exp_code}, 32'h08);
    check("sys_epc", cp0_exp_epc, 32'h80001000);
    check("sys_bd", {31'd0, cp0_exp_bd}, 32'd0);
    check("sys_flush1", {31'd0, flush}, 32'd1);
    check("sys_stall1", {31'd0, commit_stall}, 32'd1);
    step();
    check("sys_en_pulse", {31'd0, cp0_exp_en}, 32'd0);
    check("sys_flush2", {31'd0, flush}, 32'd1);
    check("sys_rv_early", {31'd0, redirect_valid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("sys_flush_off", {31'd0, flush}, 32'd0);
      check("sys_rv_hold", {31'd0, redirect_valid}, 32'd1);
      check("sys_rpc", redirect_pc, 32'hbfc00380);
      check("sys_stall", {31'd0, commit_stall}, 32'd1);
    end
    redirect_ready = 1;
    step();
    redirect_ready = 0;
    check("sys_rv_drop", {31'd0, redirect_valid}, 32'd0);
    check("sys_stall_drop", {31'd0, commit_stall}, 32'd0);

    // overflow beats daddr alignment; delay-slot EPC
    commit_valid = 1; overflow = 1; daddr_alignment_error = 1; is_branch_slot = 1;
    pc_address = 32'h80002004; mem_address = 32'h12345678;
    step();
    check("ov_code", {27'd0, cp0_exp_code}, 32'h0c);
    check("ov_epc", cp0_exp_epc, 32'h80002000);
    check("ov_bd", {31'd0, cp0_exp_bd}, 32'd1);
    check("ov_bvwen", {31'd0, cp0_exp_bad_vaddr_wen}, 32'd0);
    finish_redirect("ov");

    // load misalignment
    commit_valid = 1; daddr_alignment_error = 1; mem_wen = 0;
    pc_address = 32'h80003000; mem_address = 32'h10000003;
    step();
    check("ld_code", {27'd0, cp0_exp_code}, 32'h04);
    check("ld_bv", cp0_exp_bad_vaddr, 32'h10000003);
    check("ld_bvwen", {31'd0, cp0_exp_bad_vaddr_wen}, 32'd1);
    step();
    check("ld_bvwen_pulse", {31'd0, cp0_exp_bad_vaddr_wen}, 32'd0);
    finish_redirect("ld");

    // store misalignment
    commit_valid = 1; daddr_alignment_error = 1; mem_wen = 1;
    pc_address = 32'h80003004; mem_address = 32'h10000003;
    step();
    check("st_code", {27'd0, cp0_exp_code}, 32'h05);
    check("st_bv", cp0_exp_bad_vaddr, 32'h10000003);
    finish_redirect("st");

    // eret returns to EPC
    commit_valid = 1; eret = 1; epc_address = 32'h80000200; pc_address = 32'h80004000;
    step();
    clear_commit();
    check("eret_clean", {31'd0, cp0_exl_clean}, 32'd1);
    check("eret_en", {31'd0, cp0_exp_en}, 32'd0);
    step();
    step();
    check("eret_rv", {31'd0, redirect_valid}, 32'd1);
    check("eret_rpc", redirect_pc, 32'h80000200);
    finish_redirect("eret");

    // reset while redirect pending
    commit_valid = 1; break_ = 1; pc_address = 32'h80005000;
    step();
    clear_commit();
    check("brk_code", {27'd0, cp0_exp_code}, 32'h09);
    step();
    step();
    check("rst_pre_rv", {31'd0, redirect_valid}, 32'd1);
    #2 rst = 0;
    #1;
    check("rst_rv", {31'd0, redirect_valid}, 32'd0);
    check("rst_stall", {31'd0, commit_stall}, 32'd0);
    check("rst_rpc", redirect_pc, 32'h0);
    check("rst_code", {27'd0, cp0_exp_code}, 32'h0);
    step();
    rst = 1;
    step();
    check("rst_state", {30'd0, fsm_state}, 32'd0);
    check("rst_stall_after", {31'd0, commit_stall}, 32'd0);

    // interrupt line 3 through the synchroniser
    int_mask = 8'h08; status_ie = 1; int_raw = 8'h08;
    step();
    check("int_sync1", {24'd0, int_pending}, 32'h00);
    step();
    check("int_sync2", {24'd0, int_pending}, 32'h08);
    status_exl = 1; commit_valid = 1; pc_address = 32'h80006000;
    step();
    check("int_exl_noev", {31'd0, commit_stall}, 32'd0);
    check("int_exl_en", {31'd0, cp0_exp_en}, 32'd0);
    check("int_exl_pend", {24'd0, int_pending}, 32'h08);
    status_exl = 0;
    step();
    check("int_en", {31'd0, cp0_exp_en}, 32'd1);
    check("int_code", {27'd0, cp0_exp_code}, 32'h00);
    check("int_rpc", redirect_pc, 32'hbfc00380);
    int_raw = 0; int_mask = 0;
    finish_redirect("int");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
